// File: rtl/alu_mc_pkg.sv
// Shared opcode encoding and controller state type for the multi-cycle ALU and its decode partner.
package alu_mc_pkg;

    localparam int unsigned OPCODE_W = 3;

    typedef enum logic [OPCODE_W-1:0] {
        ALU_ADD = 3'd0,
        ALU_ADC = 3'd1,
        ALU_SUB = 3'd2,
        ALU_AND = 3'd3,
        ALU_OR  = 3'd4,
        ALU_XOR = 3'd5,
        ALU_SHL = 3'd6,
        ALU_MUL = 3'd7
    } alu_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } alu_state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier: one partial product per cycle, done pulses after WIDTH steps.
module alu_mul_seq #(
    parameter int unsigned WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int unsigned PROD_W = 2 * WIDTH;
    localparam int unsigned CNT_W  = $clog2(WIDTH + 1);

    logic [PROD_W-1:0] a_sh;
    logic [WIDTH-1:0]  b_sh;
    logic [CNT_W-1:0]  cnt;

    // Multiplicand shifts left while the multiplier is consumed LSB first.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_sh    <= '0;
            b_sh    <= '0;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                a_sh    <= PROD_W'(a);
                b_sh    <= b;
                cnt     <= '0;
                busy    <= 1'b1;
                product <= '0;
            end else if (busy) begin
                if (b_sh[0]) begin
                    product <= product + a_sh;
                end
                a_sh <= a_sh << 1;
                b_sh <= b_sh >> 1;
                cnt  <= cnt + CNT_W'(1);
                if (cnt == CNT_W'(WIDTH - 1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle arithmetic/logic ops plus an optional iterative multiplier.
module alu_mc
    import alu_mc_pkg::*;
#(
    parameter int unsigned WIDTH  = 4,
    parameter bit          MUL_EN = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 op_valid_in,
    output logic                 op_ready_out,
    input  logic [OPCODE_W-1:0]  opcode_in,
    input  logic [WIDTH-1:0]     data_0_in,
    input  logic [WIDTH-1:0]     data_1_in,
    output logic                 result_valid_out,
    output logic [WIDTH-1:0]     data_out,
    output logic                 carry_out,
    output logic                 zero_out
);

    alu_state_e            state_q, state_d;
    alu_op_e               op_c;
    logic                  accept_c;
    logic [WIDTH:0]        sum_c;
    logic [WIDTH-1:0]      alu_r_c;
    logic                  alu_cy_c;
    logic                  mul_start_c;
    logic                  load_c;
    logic [WIDTH-1:0]      res_c;
    logic                  cy_c;
    logic                  mul_busy;
    logic                  mul_done;
    logic [2*WIDTH-1:0]    mul_product;

    assign op_c     = alu_op_e'(opcode_in);
    assign accept_c = op_valid_in && op_ready_out;

    // Single-cycle datapath; MUL falls to zero here, which is the MUL_EN=0 result.
    always_comb begin
        sum_c    = '0;
        alu_r_c  = '0;
        alu_cy_c = 1'b0;
        case (op_c)
            ALU_ADD: begin
                sum_c    = {1'b0, data_0_in} + {1'b0, data_1_in};
                alu_r_c  = sum_c[WIDTH-1:0];
                alu_cy_c = sum_c[WIDTH];
            end
            ALU_ADC: begin
                sum_c    = {1'b0, data_0_in} + {1'b0, data_1_in} + (WIDTH+1)'(carry_out);
                alu_r_c  = sum_c[WIDTH-1:0];
                alu_cy_c = sum_c[WIDTH];
            end
            ALU_SUB: begin
                sum_c    = {1'b0, data_0_in} - {1'b0, data_1_in};
                alu_r_c  = sum_c[WIDTH-1:0];
                alu_cy_c = sum_c[WIDTH];
            end
            ALU_AND: alu_r_c = data_0_in & data_1_in;
            ALU_OR:  alu_r_c = data_0_in | data_1_in;
            ALU_XOR: alu_r_c = data_0_in ^ data_1_in;
            ALU_SHL: begin
                alu_r_c  = {data_0_in[WIDTH-2:0], 1'b0};
                alu_cy_c = data_0_in[WIDTH-1];
            end
            default: begin
                alu_r_c  = '0;
                alu_cy_c = 1'b0;
            end
        endcase
    end

    if (MUL_EN) begin : g_mul
        alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
            .clk     (clk),
            .reset   (reset),
            .start   (mul_start_c),
            .a       (data_0_in),
            .b       (data_1_in),
            .busy    (mul_busy),
            .done    (mul_done),
            .product (mul_product)
        );
    end else begin : g_no_mul
        assign mul_busy    = 1'b0;
        assign mul_done    = 1'b0;
        assign mul_product = '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and result-load select.
    always_comb begin
        state_d     = state_q;
        mul_start_c = 1'b0;
        load_c      = 1'b0;
        res_c       = alu_r_c;
        cy_c        = alu_cy_c;
        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    if (op_c == ALU_MUL && MUL_EN) begin
                        mul_start_c = 1'b1;
                        state_d     = ST_MUL;
                    end else begin
                        load_c = 1'b1;
                    end
                end
            end
            ST_MUL: begin
                if (mul_done && !mul_busy) begin
                    load_c  = 1'b1;
                    res_c   = mul_product[WIDTH-1:0];
                    cy_c    = |mul_product[2*WIDTH-1:WIDTH];
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Result and flags only move when a result lands; otherwise held.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out         <= '0;
            carry_out        <= 1'b0;
            zero_out         <= 1'b1;
            result_valid_out <= 1'b0;
            op_ready_out     <= 1'b1;
        end else begin
            result_valid_out <= load_c;
            op_ready_out     <= (state_d == ST_IDLE);
            if (load_c) begin
                data_out  <= res_c;
                carry_out <= cy_c;
                zero_out  <= (res_c == '0);
            end
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc: WIDTH=4, WIDTH=8 and MUL_EN=0 instances against an arithmetic reference model.
module tb_alu_mc;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic       v4, v8, v0;
    logic [2:0] op4, op8, op0;
    logic [3:0] a4, b4, a0, b0;
    logic [7:0] a8, b8;
    logic       rdy4, rdy8, rdy0, rv4, rv8, rv0;
    logic       c4, c8, c0, z4, z8, z0;
    logic [3:0] d4, d0;
    logic [7:0] d8;

    int n_vec = 0;
    int n_err = 0;
    int mc[3];

    alu_mc #(.WIDTH(4), .MUL_EN(1'b1)) dut4 (
        .clk(clk), .reset(reset), .op_valid_in(v4), .op_ready_out(rdy4), .opcode_in(op4),
        .data_0_in(a4), .data_1_in(b4), .result_valid_out(rv4), .data_out(d4),
        .carry_out(c4), .zero_out(z4));

    alu_mc #(.WIDTH(8), .MUL_EN(1'b1)) dut8 (
        .clk(clk), .reset(reset), .op_valid_in(v8), .op_ready_out(rdy8), .opcode_in(op8),
        .data_0_in(a8), .data_1_in(b8), .result_valid_out(rv8), .data_out(d8),
        .carry_out(c8), .zero_out(z8));

    alu_mc #(.WIDTH(4), .MUL_EN(1'b0)) dut0 (
        .clk(clk), .reset(reset), .op_valid_in(v0), .op_ready_out(rdy0), .opcode_in(op0),
        .data_0_in(a0), .data_1_in(b0), .result_valid_out(rv0), .data_out(d0),
        .carry_out(c0), .zero_out(z0));

    task automatic check(input string tag, input int obs, input int exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int width_of(input int sel);
        return (sel == 1) ? 8 : 4;
    endfunction

    // Reference: plain integer arithmetic on the opcode definitions.
    function automatic void model(input int sel, input int op, input int a, input int b,
                                  input int cin, output int r, output int c);
        int w, m, s;
        w = width_of(sel);
        m = (1 << w) - 1;
        c = 0;
        case (op)
            0: begin s = a + b;       r = s & m; c = (s >> w) & 1; end
            1: begin s = a + b + cin; r = s & m; c = (s >> w) & 1; end
            2: begin r = (a - b) & m; c = (a < b) ? 1 : 0; end
            3: r = a & b;
            4: r = a | b;
            5: r = a ^ b;
            6: begin r = (a << 1) & m; c = (a >> (w - 1)) & 1; end
            default: begin
                s = a * b;
                r = s & m;
                c = ((s >> w) != 0) ? 1 : 0;
                if (sel == 2) begin r = 0; c = 0; end
            end
        endcase
    endfunction

    task automatic drive(input int sel, input bit v, input int op, input int a, input int b);
        case (sel)
            0: begin v4 = v; op4 = 3'(op); a4 = 4'(a); b4 = 4'(b); end
            1: begin v8 = v; op8 = 3'(op); a8 = 8'(a); b8 = 8'(b); end
            default: begin v0 = v; op0 = 3'(op); a0 = 4'(a); b0 = 4'(b); end
        endcase
    endtask

    task automatic observe(input int sel, output int rv, output int rdy, output int d,
                           output int c, output int z);
        case (sel)
            0: begin rv = int'(rv4); rdy = int'(rdy4); d = int'(d4); c = int'(c4); z = int'(z4); end
            1: begin rv = int'(rv8); rdy = int'(rdy8); d = int'(d8); c = int'(c8); z = int'(z8); end
            default: begin rv = int'(rv0); rdy = int'(rdy0); d = int'(d0); c = int'(c0); z = int'(z0); end
        endcase
    endtask

    task automatic check_reset(input int sel);
        int rv, rdy, d, c, z;
        observe(sel, rv, rdy, d, c, z);
        check("reset_valid", rv, 0);
        check("reset_ready", rdy, 1);
        check("reset_data", d, 0);
        check("reset_carry", c, 0);
        check("reset_zero", z, 1);
    endtask

    // One op: accept, wait for the result (junk on the inputs while a MUL is busy), check, idle one cycle.
    task automatic run(input int sel, input int op, input int a_in, input int b_in);
        int w, a, b, r, c, rv, rdy, d, cy, z, lat, low;
        bit is_mul;
        w = width_of(sel);
        a = a_in & ((1 << w) - 1);
        b = b_in & ((1 << w) - 1);
        is_mul = (op == 7) && (sel != 2);
        model(sel, op, a, b, mc[sel], r, c);
        @(negedge clk);
        drive(sel, 1'b1, op, a, b);
        @(posedge clk);
        #1;
        if (is_mul) begin
            lat = 0;
            low = 0;
            observe(sel, rv, rdy, d, cy, z);
            while (rv == 0 && lat < 4 * w) begin
                if (rdy == 0) low++;
                drive(sel, 1'b1, int'($urandom_range(0, 7)), int'($urandom), int'($urandom));
                @(posedge clk);
                #1;
                lat++;
                observe(sel, rv, rdy, d, cy, z);
            end
            drive(sel, 1'b0, 0, 0, 0);
            check("mul_latency", lat, w + 1);
            check("mul_ready_low", low, w + 1);
        end else begin
            drive(sel, 1'b0, 0, 0, 0);
            observe(sel, rv, rdy, d, cy, z);
        end
        check("res_valid", rv, 1);
        check("res_ready", rdy, 1);
        check("res_data", d, r);
        check("res_carry", cy, c);
        check("res_zero", z, (r == 0) ? 1 : 0);
        mc[sel] = c;
        @(posedge clk);
        #1;
        observe(sel, rv, rdy, d, cy, z);
        check("idle_valid", rv, 0);
        check("idle_hold_data", d, r);
        check("idle_hold_carry", cy, c);
    endtask

    initial begin
        int rv, rdy, d, cy, z, stray;
        reset = 1'b1;
        for (int s = 0; s < 3; s++) begin
            drive(s, 1'b0, 0, 0, 0);
            mc[s] = 0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int s = 0; s < 3; s++) check_reset(s);
        @(negedge clk);
        reset = 1'b0;

        // Directed WIDTH=4 sequence
        run(0, 0, 9, 8);
        run(0, 1, 2, 3);
        run(0, 2, 3, 5);
        run(0, 2, 5, 5);
        run(0, 7, 7, 3);
        run(0, 7, 3, 5);

        // Back-to-back ADD, XOR, SHL
        @(negedge clk);
        drive(0, 1'b1, 0, 1, 2);
        @(posedge clk);
        #1;
        observe(0, rv, rdy, d, cy, z);
        check("b2b_add_valid", rv, 1);
        check("b2b_add_data", d, 3);
        drive(0, 1'b1, 5, 6, 3);
        @(posedge clk);
        #1;
        observe(0, rv, rdy, d, cy, z);
        check("b2b_xor_valid", rv, 1);
        check("b2b_xor_data", d, 5);
        drive(0, 1'b1, 6, 8, 0);
        @(posedge clk);
        #1;
        observe(0, rv, rdy, d, cy, z);
        drive(0, 1'b0, 0, 0, 0);
        check("b2b_shl_valid", rv, 1);
        check("b2b_shl_data", d, 0);
        check("b2b_shl_carry", cy, 1);
        check("b2b_shl_zero", z, 1);
        mc[0] = 1;
        @(posedge clk);
        #1;
        observe(0, rv, rdy, d, cy, z);
        check("b2b_after_valid", rv, 0);

        // Reset two cycles into a MUL
        @(negedge clk);
        drive(0, 1'b1, 7, 7, 3);
        @(posedge clk);
        #1;
        drive(0, 1'b0, 0, 0, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check_reset(0);
        @(negedge clk);
        reset = 1'b0;
        for (int s = 0; s < 3; s++) mc[s] = 0;
        stray = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            observe(0, rv, rdy, d, cy, z);
            if (rv != 0) stray++;
        end
        check("reset_mul_stray_valid", stray, 0);
        check("reset_mul_ready", rdy, 1);
        run(0, 0, 1, 1);

        // WIDTH=8
        run(1, 7, 255, 255);
        for (int i = 0; i < 15; i++) run(1, int'($urandom_range(0, 7)), int'($urandom), int'($urandom));

        // MUL_EN=0
        run(2, 7, 7, 3);
        for (int i = 0; i < 15; i++) run(2, int'($urandom_range(0, 7)), int'($urandom), int'($urandom));

        // Randomized WIDTH=4
        for (int i = 0; i < 40; i++) run(0, int'($urandom_range(0, 7)), int'($urandom), int'($urandom));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
